// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/DMA main-memory arbiter: FSM states, read-owner tags,
// write payload bundle and counter sizing.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        CPU_PRI    = 2'd0,
        DMA_FORCED = 2'd1,
        DMA_LOCKED = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    typedef struct packed {
        logic              write;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
        logic              wgrubby;
    } wr_payload_t;

    // Terminal count for a limit expressed as a number of cycles.
    function automatic logic [CNT_W-1:0] cnt_last(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals around the arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  cpu_valid;
    logic                  cpu_write;
    logic [MASK_W-1:0]     cpu_wmask;
    logic [DATA_W-1:0]     cpu_wdata;
    logic                  cpu_wgrubby;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_rgrubby;

    logic                  dma_req;
    logic                  dma_lock;
    logic                  dma_write;
    logic [MASK_W-1:0]     dma_wmask;
    logic [DATA_W-1:0]     dma_wdata;
    logic                  dma_wgrubby;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic                  dma_gnt;
    logic                  dma_rvalid;
    logic [DATA_W-1:0]     dma_rdata;
    logic                  dma_rgrubby;

    logic                  mem_write;
    logic [MASK_W-1:0]     mem_wmask;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_wgrubby;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rgrubby;

    modport slave (
        input  cpu_valid, cpu_write, cpu_wmask, cpu_wdata, cpu_wgrubby, cpu_addr,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_rgrubby,
        input  dma_req, dma_lock, dma_write, dma_wmask, dma_wdata, dma_wgrubby, dma_addr,
        output dma_gnt, dma_rvalid, dma_rdata, dma_rgrubby,
        output mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr,
        input  mem_rdata, mem_rgrubby
    );

    modport master (
        output cpu_valid, cpu_write, cpu_wmask, cpu_wdata, cpu_wgrubby, cpu_addr,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_rgrubby,
        output dma_req, dma_lock, dma_write, dma_wmask, dma_wdata, dma_wgrubby, dma_addr,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_rgrubby,
        input  mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr,
        output mem_rdata, mem_rgrubby
    );

endinterface

// File: rtl/mem_arbiter_arb_starve_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_starve_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port main memory: CPU has fixed priority,
// a starvation counter forces DMA through and a bounded lock gives DMA atomic sequences.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned LOCK_MAX     = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [CNT_W-1:0]      starve_cnt, lock_cnt;
    logic                  starve_inc, starve_clr, lock_inc, lock_clr;
    logic                  dma_wins_c, cpu_wins_c;
    wr_payload_t           cpu_pl, dma_pl, mem_pl;
    logic [ADDR_WIDTH-1:0] addr_sel_c;

    arb_starve_counter #(.WIDTH(CNT_W)) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (starve_clr),
        .inc   (starve_inc),
        .count (starve_cnt)
    );

    arb_starve_counter #(.WIDTH(CNT_W)) u_lock_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (lock_clr),
        .inc   (lock_inc),
        .count (lock_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CPU_PRI;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Grant decision, counter control and next state.
    always_comb begin
        state_d    = state_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        lock_inc   = 1'b0;
        lock_clr   = 1'b0;
        dma_wins_c = 1'b0;
        cpu_wins_c = 1'b0;
        owner_d    = OWN_NONE;

        unique case (state_q)
            CPU_PRI: begin
                dma_wins_c = bus.dma_req & ~bus.cpu_valid;
                if (dma_wins_c) begin
                    starve_clr = 1'b1;
                    if (bus.dma_lock) begin
                        state_d  = DMA_LOCKED;
                        lock_clr = 1'b1;
                    end
                end else if (bus.dma_req & bus.cpu_valid) begin
                    starve_inc = 1'b1;
                    if (starve_cnt == cnt_last(STARVE_LIMIT)) begin
                        state_d = DMA_FORCED;
                    end
                end
            end
            DMA_FORCED: begin
                dma_wins_c = bus.dma_req;
                starve_clr = 1'b1;
                if (bus.dma_req & bus.dma_lock) begin
                    state_d  = DMA_LOCKED;
                    lock_clr = 1'b1;
                end else begin
                    state_d = CPU_PRI;
                end
            end
            DMA_LOCKED: begin
                // A request in the timeout cycle is still served; the exit lands next cycle.
                dma_wins_c = bus.dma_req;
                starve_clr = 1'b1;
                lock_inc   = 1'b1;
                if (!bus.dma_lock || (lock_cnt == cnt_last(LOCK_MAX))) begin
                    state_d  = CPU_PRI;
                    lock_clr = 1'b1;
                end
            end
            default: begin
                state_d = CPU_PRI;
            end
        endcase

        cpu_wins_c = bus.cpu_valid & ~dma_wins_c & (state_q != DMA_LOCKED);

        if (rst) begin
            dma_wins_c = 1'b0;
            cpu_wins_c = 1'b0;
        end

        if (dma_wins_c && !bus.dma_write) begin
            owner_d = OWN_DMA;
        end else if (cpu_wins_c && !bus.cpu_write) begin
            owner_d = OWN_CPU;
        end
    end

    assign cpu_pl = {bus.cpu_write, bus.cpu_wmask, bus.cpu_wdata, bus.cpu_wgrubby};
    assign dma_pl = {bus.dma_write, bus.dma_wmask, bus.dma_wdata, bus.dma_wgrubby};

    // Memory port follows the winner; the CPU side is parked on it when nobody wins.
    assign mem_pl     = dma_wins_c ? dma_pl : cpu_pl;
    assign addr_sel_c = dma_wins_c ? bus.dma_addr : bus.cpu_addr;

    assign bus.mem_addr    = addr_sel_c;
    assign bus.mem_wmask   = mem_pl.wmask;
    assign bus.mem_wdata   = mem_pl.wdata;
    assign bus.mem_wgrubby = mem_pl.wgrubby;
    assign bus.mem_write   = dma_wins_c ? dma_pl.write : (cpu_pl.write & cpu_wins_c);

    assign bus.dma_gnt   = dma_wins_c;
    assign bus.cpu_ready = cpu_wins_c;

    assign bus.cpu_rvalid  = (owner_q == OWN_CPU);
    assign bus.dma_rvalid  = (owner_q == OWN_DMA);
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.cpu_rgrubby = bus.mem_rgrubby;
    assign bus.dma_rdata   = bus.mem_rdata;
    assign bus.dma_rgrubby = bus.mem_rgrubby;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle registered-read memory
// (byte masks, grubby bit) standing in for the main-memory block.
module tb_mem_arbiter;

    localparam int unsigned AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (8),
        .LOCK_MAX     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [32:0] mem [0:(1<<AW)-1];
    logic [32:0] wword;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] <= {1'(i & 1), 32'hA5A50000 | 32'(i)};
        end
        mem[14'h3F80] <= {1'b1, 32'hDEADBEEF};
        mem[14'h0010] <= {1'b0, 32'h55667788};
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            wword = mem[bus.mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) wword[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
            wword[32] = bus.mem_wgrubby;
            mem[bus.mem_addr] <= wword;
        end
        bus.mem_rdata   <= mem[bus.mem_addr][31:0];
        bus.mem_rgrubby <= mem[bus.mem_addr][32];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_idle();
        bus.cpu_valid   = 1'b0;
        bus.cpu_write   = 1'b0;
        bus.cpu_wmask   = 4'h0;
        bus.cpu_wdata   = 32'h0;
        bus.cpu_wgrubby = 1'b0;
        bus.dma_req     = 1'b0;
        bus.dma_lock    = 1'b0;
        bus.dma_write   = 1'b0;
        bus.dma_wmask   = 4'h0;
        bus.dma_wdata   = 32'h0;
        bus.dma_wgrubby = 1'b0;
    endtask

    initial begin
        logic exp_dma;
        drive_idle();
        bus.cpu_addr  = 14'h0;
        bus.dma_addr  = 14'h0;
        bus.cpu_valid = 1'b1;
        bus.dma_req   = 1'b1;

        // reset: grants are held off while rst is high
        @(negedge clk); #1;
        check("rst_cpu_ready", 64'(bus.cpu_ready), 64'd0);
        check("rst_dma_gnt", 64'(bus.dma_gnt), 64'd0);
        check("rst_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        check("rst_dma_rvalid", 64'(bus.dma_rvalid), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();

        // CPU read of 0x3F80
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 14'h3F80;
        #1;
        check("t1_cpu_ready", 64'(bus.cpu_ready), 64'd1);
        check("t1_dma_gnt", 64'(bus.dma_gnt), 64'd0);
        check("t1_mem_addr", 64'(bus.mem_addr), 64'h3F80);
        check("t1_mem_write", 64'(bus.mem_write), 64'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("t1_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        check("t1_cpu_rdata", 64'(bus.cpu_rdata), 64'hDEADBEEF);
        check("t1_cpu_rgrubby", 64'(bus.cpu_rgrubby), 64'd1);
        check("t1_dma_rvalid", 64'(bus.dma_rvalid), 64'd0);
        check("t1_dma_rdata", 64'(bus.dma_rdata), 64'hDEADBEEF);
        check("t1_idle_mem_write", 64'(bus.mem_write), 64'd0);
        check("t1_idle_mem_addr", 64'(bus.mem_addr), 64'h3F80);

        // DMA masked write while CPU idle, then CPU reads it back
        @(negedge clk);
        bus.dma_req   = 1'b1;
        bus.dma_write = 1'b1;
        bus.dma_wmask = 4'b0011;
        bus.dma_wdata = 32'h1234ABCD;
        bus.dma_addr  = 14'h0010;
        #1;
        check("t3_dma_gnt", 64'(bus.dma_gnt), 64'd1);
        check("t3_cpu_ready", 64'(bus.cpu_ready), 64'd0);
        check("t3_mem_write", 64'(bus.mem_write), 64'd1);
        check("t3_mem_wmask", 64'(bus.mem_wmask), 64'h3);
        check("t3_mem_wdata", 64'(bus.mem_wdata), 64'h1234ABCD);
        check("t3_mem_addr", 64'(bus.mem_addr), 64'h0010);
        @(negedge clk);
        drive_idle();
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 14'h0010;
        #1;
        check("t3_no_dma_rvalid", 64'(bus.dma_rvalid), 64'd0);
        check("t3_no_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        check("t3_rd_cpu_ready", 64'(bus.cpu_ready), 64'd1);
        @(negedge clk);
        drive_idle();
        #1;
        check("t3_rd_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        check("t3_rd_cpu_rdata", 64'(bus.cpu_rdata), 64'h5566ABCD);

        // contention: 8 refusals, forced DMA grant, then a fresh starvation window
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.cpu_valid = 1'b1;
                bus.cpu_addr  = 14'h0100;
                bus.dma_req   = 1'b1;
                bus.dma_addr  = 14'h0200;
            end
            #1;
            exp_dma = (c == 8) || (c == 17);
            check($sformatf("t2_dma_gnt_c%0d", c), 64'(bus.dma_gnt), 64'(exp_dma));
            check($sformatf("t2_cpu_ready_c%0d", c), 64'(bus.cpu_ready), 64'(!exp_dma));
            if (c == 9) begin
                check("t2_dma_rvalid", 64'(bus.dma_rvalid), 64'd1);
                check("t2_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
                check("t2_dma_rdata", 64'(bus.dma_rdata), 64'hA5A50200);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("t2_last_dma_rvalid", 64'(bus.dma_rvalid), 64'd1);

        // DMA lock: CPU stalled through idle DMA cycles, released after lock drops
        @(negedge clk);
        bus.dma_req  = 1'b1;
        bus.dma_lock = 1'b1;
        bus.dma_addr = 14'h0010;
        #1;
        check("t4_lock_gnt", 64'(bus.dma_gnt), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cpu_valid = 1'b1;
            bus.cpu_addr  = 14'h0100;
            bus.dma_req   = (i % 2 == 1);
            #1;
            check($sformatf("t4_cpu_stall_%0d", i), 64'(bus.cpu_ready), 64'd0);
            check($sformatf("t4_dma_gnt_%0d", i), 64'(bus.dma_gnt), 64'(i % 2 == 1));
            if (i == 0) begin
                check("t4_dma_rvalid", 64'(bus.dma_rvalid), 64'd1);
                check("t4_dma_rdata", 64'(bus.dma_rdata), 64'h5566ABCD);
            end
        end
        @(negedge clk);
        bus.dma_lock = 1'b0;
        bus.dma_req  = 1'b0;
        #1;
        check("t4_unlock_cycle", 64'(bus.cpu_ready), 64'd0);
        @(negedge clk); #1;
        check("t4_cpu_back", 64'(bus.cpu_ready), 64'd1);
        check("t4_cpu_back_gnt", 64'(bus.dma_gnt), 64'd0);

        // lock timeout: 16 locked cycles, 8 refusals, forced grant relocks for 16 more
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        bus.dma_req   = 1'b1;
        bus.dma_lock  = 1'b1;
        #1;
        check("t5_lock_gnt", 64'(bus.dma_gnt), 64'd1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.cpu_valid = 1'b1;
            #1;
            exp_dma = (c < 16) || (c >= 24);
            check($sformatf("t5_dma_gnt_c%0d", c), 64'(bus.dma_gnt), 64'(exp_dma));
            check($sformatf("t5_cpu_ready_c%0d", c), 64'(bus.cpu_ready), 64'(!exp_dma));
        end
        @(negedge clk);
        bus.dma_lock = 1'b0;
        bus.dma_req  = 1'b0;
        #1;
        check("t5_last_locked", 64'(bus.cpu_ready), 64'd0);
        @(negedge clk); #1;
        check("t5_cpu_back", 64'(bus.cpu_ready), 64'd1);

        // reset between a locked DMA read grant and its data cycle
        @(negedge clk);
        drive_idle();
        bus.dma_req  = 1'b1;
        bus.dma_lock = 1'b1;
        bus.dma_addr = 14'h0200;
        #1;
        check("t6_dma_gnt", 64'(bus.dma_gnt), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_dma_rvalid", 64'(bus.dma_rvalid), 64'd0);
        check("t6_rst_dma_gnt", 64'(bus.dma_gnt), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 14'h0100;
        #1;
        check("t6_post_dma_rvalid", 64'(bus.dma_rvalid), 64'd0);
        check("t6_post_cpu_ready", 64'(bus.cpu_ready), 64'd1);
        check("t6_post_dma_gnt", 64'(bus.dma_gnt), 64'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("t6_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        check("t6_cpu_rdata", 64'(bus.cpu_rdata), 64'hA5A50100);
        check("t6_dma_rvalid_off", 64'(bus.dma_rvalid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
